// File: rtl/product_accumulator.sv
// Sums a stream of upstream products into one result per job.
// Three-state job FSM: IDLE, ACCUM (one beat per cycle), DONE.
module product_accumulator #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [DATA_W-1:0] prod,
  output logic              prod_ready,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [DATA_W-1:0] sum,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  cnt_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_d;
  logic              ovf_q;
  logic              ovf_d;
  logic [DATA_W:0]   add;
  logic              last;

  // Extra top bit of the adder is the carry-out.
  assign add  = {1'b0, acc_q} + {1'b0, prod};

  // cnt_q never exceeds len_q-1, so it cannot wrap
  // before the compare even at the largest len.
  assign last = (cnt_q == (len_q - LEN_W'(1)));

  // Outputs decode straight from registered state.
  assign prod_ready = (state_q == ACCUM);
  assign sum_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign sum        = acc_q;
  assign overflow   = ovf_q;

  // Next-state and datapath updates; hold by default.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = '0;
          if (len == '0) begin
            len_d   = '0;
            state_d = DONE;
          end else begin
            len_d   = len;
            state_d = ACCUM;
          end
        end
      end
      (state_q == ACCUM): begin
        if (prod_valid) begin
          acc_d = add[DATA_W-1:0];
          ovf_d = ovf_q | add[DATA_W];
          cnt_d = cnt_q + LEN_W'(1);
          if (last) begin
            state_d = DONE;
          end
        end
      end
      (state_q == DONE): begin
        if (sum_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator, beat counter, latched length, sticky carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the product and sum width.
REQ-002 The block SHALL have parameter LEN_W, default 16, giving the beat-count width.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port start, input, 1, a one-cycle request to begin a new accumulation.
REQ-006 Port len, input, LEN_W, the number of products to accumulate, sampled when start is accepted.
REQ-007 Port prod_valid, input, 1, the upstream multiplier output is valid.
REQ-008 Port prod, input, DATA_W, the upstream multiplier result.
REQ-009 Port prod_ready, output, 1, the block accepts prod this cycle.
REQ-010 Port sum_valid, output, 1, the accumulated sum is available.
REQ-011 Port sum_ready, input, 1, the downstream consumer accepts the sum.
REQ-012 Port sum, output, DATA_W, the accumulated result.
REQ-013 Port overflow, output, 1, sticky carry-out flag for the current accumulation.
REQ-014 Port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-016 In IDLE, start=1 with len!=0 SHALL latch len, clear the accumulator, beat counter and overflow, and move to ACCUM next cycle.
REQ-017 In IDLE, start=1 with len==0 SHALL clear the accumulator and overflow and move directly to DONE, so sum=0.
REQ-018 start SHALL be ignored in ACCUM and DONE; it is not queued.
REQ-019 prod_ready SHALL be 1 only in ACCUM; it is a registered state decode with no combinational path from prod_valid.
REQ-020 A beat is accepted when prod_valid&&prod_ready; prod_valid in IDLE or DONE SHALL have no effect.
REQ-021 On each accepted beat, acc SHALL become (acc+prod) mod 2^DATA_W and the beat counter SHALL increment.
REQ-022 The carry-out of any accepted addition SHALL set overflow; overflow SHALL stay set until the next accepted start or reset.
REQ-023 When the accepted beat is beat number len (counter==len-1), the FSM SHALL move to DONE next cycle.
REQ-024 sum_valid SHALL rise exactly one cycle after the final beat is accepted.
REQ-025 In DONE, sum_valid SHALL be 1 and sum and overflow SHALL hold stable until sum_ready=1.
REQ-026 In DONE, sum_ready=1 SHALL return the FSM to IDLE next cycle; sum and overflow SHALL retain their values in IDLE.
REQ-027 The earliest next start after a DONE handshake SHALL be accepted on the first IDLE cycle; throughput is len+2 cycles per job.
REQ-028 len=2^LEN_W-1 SHALL complete correctly, with no counter wrap before the terminal compare.
REQ-029 Back-to-back beats with prod_valid held high SHALL each be accepted, one beat per cycle.

Reset
REQ-030 While rst_n=0, the state SHALL be IDLE and prod_ready, sum_valid, busy, overflow, sum, the accumulator and the counter SHALL all be 0, independent of clk.
REQ-031 rst_n asserted mid-ACCUM or mid-DONE SHALL abort the job immediately; the partial sum is discarded and no sum_valid is produced.
REQ-032 The first start after rst_n deasserts SHALL be accepted on the first rising edge at which rst_n=1.

Verification
REQ-033 Reset then idle: rst_n low for 3 cycles -> all outputs 0 and state IDLE; prod_valid=1 in IDLE -> prod_ready stays 0.
REQ-034 Basic job: start with len=3, products 5, 7, 11 back-to-back -> sum_valid one cycle after the third beat, sum=23, overflow=0.
REQ-035 Stalls: len=4, with prod_valid gapped and sum_ready held low for 5 cycles -> sum=sum of the 4 products, held stable, sum_valid=1 until the handshake completes.
REQ-036 Overflow: len=2, products 0xFFFF_FFFF_FFFF_FFFF and 2 -> sum=1, overflow=1; the next job with len=1, product 4 -> sum=4, overflow=0.
REQ-037 Zero length: start with len=0 -> DONE next cycle, sum=0, sum_valid=1, prod_ready never 1.
REQ-038 Abort and ignore: start is pulsed during ACCUM and has no effect; rst_n is pulsed after 2 of 4 beats -> outputs 0; a following job with len=1, product 9 -> sum=9.
